mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and data width.
REQ-002 SHALL have parameter LAT, default 2, meaning memory access cycles, legal range 1..15.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low (reset=0 resets).
REQ-005 SHALL have ports: i_req  in  1  fetch read request; i_addr  in  XLEN  fetch address.
REQ-006 SHALL have ports: i_ready  out  1  fetch done pulse; i_rdata  out  XLEN  fetch data.
REQ-007 SHALL have ports: d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  XLEN  data address; d_wdata  in  XLEN  data to write.
REQ-008 SHALL have ports: d_ready  out  1  data done pulse; d_rdata  out  XLEN  load data.
REQ-009 SHALL have ports: mem_en  out  1  access enable; mem_we  out  1  write enable; mem_addr  out  XLEN  address; mem_wdata  out  XLEN  write data; mem_rdata  in  XLEN  read data; busy  out  1  state not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE, with a 4-bit latency counter.
REQ-011 SHALL, in IDLE with d_req=1, go to BUSY_D; with d_req=0 and i_req=1, go to BUSY_I; otherwise stay in IDLE.
REQ-012 SHALL break the priority for fairness: if the last completed access was data and both requests are present in IDLE, grant fetch.
REQ-013 SHALL, in BUSY_x, drive mem_en=1 and the granted port's address; drive mem_we=d_we and mem_wdata=d_wdata only in BUSY_D; otherwise mem_en=mem_we=0 and addr/wdata=0.
REQ-014 SHALL clear the counter on entry to BUSY_x, increment it each BUSY cycle, and at count LAT-1 capture mem_rdata into the granted port's rdata register (reads only), then go to DONE.
REQ-015 SHALL assert exactly one of i_ready/d_ready (the served port) for the single DONE cycle; DONE always returns to IDLE.
REQ-016 SHALL hold i_rdata/d_rdata between completions; a write does not modify d_rdata.
REQ-017 SHALL give latency: req seen in IDLE at cycle 0 -> BUSY cycles 1..LAT -> ready at cycle LAT+1 -> IDLE at LAT+2; next grant is sampled no earlier than LAT+2.
REQ-018 SHALL require requesters to hold req/addr/we/wdata stable until their ready; a request withdrawn mid-access still completes and pulses ready.
REQ-019 SHALL ignore requests arriving during BUSY/DONE until IDLE; a request raised in the DONE cycle is not granted in that cycle.
REQ-020 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-021 SHALL, on reset=0, immediately force state=IDLE, counter=0, last-served=fetch, mem_en=mem_we=0, mem_addr=mem_wdata=0, i_ready=d_ready=0, i_rdata=d_rdata=0, busy=0.
REQ-022 SHALL abort an in-flight access on reset, issue no ready for it, and begin arbitration on the first edge after reset=1.

Structure
REQ-023 SHALL place the FSM state enum and the LAT default in shared package riscv_mem_pkg.
REQ-024 SHALL use one sub-module flopenr (enable, async active-low reset register) per rdata capture register; all other logic is inline.

Verification
REQ-025 SHALL cover: LAT=2, fetch i_addr=0x100, mem_rdata=0x00500093 -> mem_en cycles 1-2, i_ready at cycle 3, i_rdata=0x00500093.
REQ-026 SHALL cover: both req in IDLE, last=fetch -> d served first (d_ready cycle 3), then i (i_ready cycle 7).
REQ-027 SHALL cover: store d_we=1, addr 0x2000, wdata 0xDEADBEEF -> mem_we=1 for 2 cycles, d_ready pulse, d_rdata unchanged.
REQ-028 SHALL cover: d_req held continuously plus i_req -> grants alternate D,I,D,I; no port is starved.
REQ-029 SHALL cover: reset=0 in BUSY_D cycle 1 -> mem_en=0 with no clock edge, no d_ready; re-request after release completes normally.
REQ-030 SHALL cover: LAT=1, fetch -> ready at cycle 2; i_req raised in DONE cycle is granted from IDLE at cycle 3.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM encoding and default latency.
`default_nettype none

package riscv_mem_pkg;

    localparam int LAT_DEFAULT = 2;
    localparam int CNT_W       = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_BUSY_I = 2'd1;
    localparam state_t S_BUSY_D = 2'd2;
    localparam state_t S_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset; holds its value when en is low.
`default_nettype none

module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory,
// alternating grants when both ports contend.
`default_nettype none

module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LAT  = LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ready,
    output logic [XLEN-1:0] i_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ready,
    output logic [XLEN-1:0] d_rdata,

    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    // Port of the current (or most recently completed) access; 1 = data.
    logic             serve_d;
    logic             grant;
    logic             grant_d;
    logic             busy_i;
    logic             busy_d;
    logic             last_beat;

    assign busy_i    = (state == S_BUSY_I);
    assign busy_d    = (state == S_BUSY_D);
    assign last_beat = (cnt == CNT_W'(LAT - 1));

    // Data normally wins, but a data completion hands the next contended grant to fetch.
    always_comb begin
        grant   = 1'b0;
        grant_d = 1'b0;
        if (d_req && i_req) begin
            grant   = 1'b1;
            grant_d = ~serve_d;
        end else if (d_req) begin
            grant   = 1'b1;
            grant_d = 1'b1;
        end else if (i_req) begin
            grant   = 1'b1;
            grant_d = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_next = grant_d ? S_BUSY_D : S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (last_beat) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            serve_d <= 1'b0;
        end else begin
            state <= state_next;
            if (busy_i || busy_d) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if ((state == S_IDLE) && grant) begin
                serve_d <= grant_d;
            end
        end
    end

    assign mem_en    = busy_i | busy_d;
    assign mem_we    = busy_d & d_we;
    assign mem_addr  = busy_d ? d_addr : (busy_i ? i_addr : '0);
    assign mem_wdata = busy_d ? d_wdata : '0;

    assign i_ready = (state == S_DONE) & ~serve_d;
    assign d_ready = (state == S_DONE) &  serve_d;
    assign busy    = (state != S_IDLE);

    flopenr #(
        .WIDTH (XLEN)
    ) u_i_rdata (
        .clk   (clk),
        .reset (reset),
        .en    (busy_i && last_beat),
        .d     (mem_rdata),
        .q     (i_rdata)
    );

    // Stores leave the load-data register untouched.
    flopenr #(
        .WIDTH (XLEN)
    ) u_d_rdata (
        .clk   (clk),
        .reset (reset),
        .en    (busy_d && last_beat && !d_we),
        .d     (mem_rdata),
        .q     (d_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LAT=2 instance for the main scenarios, a LAT=1 instance for back-to-back fetches.
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        logic        is_d;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    logic [31:0] mem [logic [31:0]];

    logic        a_i_req, a_d_req, a_d_we;
    logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
    logic        a_i_ready, a_d_ready, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_i_req, b_d_req, b_d_we;
    logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
    logic        b_i_ready, b_d_ready, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.XLEN(32), .LAT(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.XLEN(32), .LAT(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem[a_mem_addr] = a_mem_wdata;
    end

    always @(negedge clk) begin
        a_mem_rdata <= a_mem_en ? rd(a_mem_addr) : 32'h0;
        b_mem_rdata <= b_mem_en ? rd(b_mem_addr) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (a_i_ready || a_d_ready) begin
            chk("a_single_ready", 32'(a_i_ready & a_d_ready), 32'h0);
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_ready: got i=%0b d=%0b, expected none (cycle %0d)",
                         a_i_ready, a_d_ready, cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_port_is_d", 32'(a_d_ready), 32'(ea.is_d));
                chk("a_ready_cycle", 32'(cyc), 32'(ea.cyc));
                chk("a_rdata", a_d_ready ? a_d_rdata : a_i_rdata, ea.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b_i_ready || b_d_ready) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_ready: got i=%0b d=%0b, expected none (cycle %0d)",
                         b_i_ready, b_d_ready, cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_port_is_d", 32'(b_d_ready), 32'(eb.is_d));
                chk("b_ready_cycle", 32'(cyc), 32'(eb.cyc));
                chk("b_rdata", b_d_ready ? b_d_rdata : b_i_rdata, eb.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        a_i_req = 0; a_d_req = 0; a_d_we = 0;
        a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
        b_i_req = 0; b_d_req = 0; b_d_we = 0;
        b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
        mem[32'h100] = 32'h00500093;
        mem[32'h104] = 32'h00A00113;
        mem[32'h300] = 32'hCAFEF00D;

        repeat (2) @(negedge clk);
        chk("rst_mem_en", 32'(a_mem_en), 32'h0);
        chk("rst_mem_we", 32'(a_mem_we), 32'h0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_mem_wdata", a_mem_wdata, 32'h0);
        chk("rst_ready", 32'({a_i_ready, a_d_ready}), 32'h0);
        chk("rst_i_rdata", a_i_rdata, 32'h0);
        chk("rst_d_rdata", a_d_rdata, 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Both requests after reset: data first, fetch four cycles later.
        c = cyc;
        a_i_req = 1; a_i_addr = 32'h100;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h300;
        qa.push_back('{1'b1, c + 3, 32'hCAFEF00D});
        qa.push_back('{1'b0, c + 7, 32'h00500093});
        repeat (3) @(negedge clk);
        a_d_req = 0;
        repeat (4) @(negedge clk);
        a_i_req = 0;
        @(negedge clk);

        // Single fetch, checking the memory-side window.
        c = cyc;
        a_i_req = 1; a_i_addr = 32'h104;
        qa.push_back('{1'b0, c + 3, 32'h00A00113});
        @(negedge clk);
        chk("f_mem_en_c1", 32'(a_mem_en), 32'h1);
        chk("f_mem_addr_c1", a_mem_addr, 32'h104);
        chk("f_mem_we_c1", 32'(a_mem_we), 32'h0);
        @(negedge clk);
        chk("f_mem_en_c2", 32'(a_mem_en), 32'h1);
        @(negedge clk);
        chk("f_mem_en_done", 32'(a_mem_en), 32'h0);
        chk("f_busy_done", 32'(a_busy), 32'h1);
        a_i_req = 0;
        @(negedge clk);
        chk("f_busy_idle", 32'(a_busy), 32'h0);

        // Both held continuously: grants alternate D, I, D, I.
        c = cyc;
        a_i_req = 1; a_i_addr = 32'h100;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h300;
        qa.push_back('{1'b1, c + 3,  32'hCAFEF00D});
        qa.push_back('{1'b0, c + 7,  32'h00500093});
        qa.push_back('{1'b1, c + 11, 32'hCAFEF00D});
        qa.push_back('{1'b0, c + 15, 32'h00500093});
        repeat (15) @(negedge clk);
        a_i_req = 0; a_d_req = 0;
        @(negedge clk);

        // Store: mem_we for two cycles, d_rdata keeps the previous load.
        c = cyc;
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h2000; a_d_wdata = 32'hDEADBEEF;
        qa.push_back('{1'b1, c + 3, 32'hCAFEF00D});
        @(negedge clk);
        chk("st_mem_we_c1", 32'(a_mem_we), 32'h1);
        chk("st_mem_addr", a_mem_addr, 32'h2000);
        chk("st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_mem_we_c2", 32'(a_mem_we), 32'h1);
        @(negedge clk);
        chk("st_mem_we_done", 32'(a_mem_we), 32'h0);
        chk("st_mem_wdata_done", a_mem_wdata, 32'h0);
        a_d_req = 0; a_d_we = 0; a_d_wdata = 0;
        @(negedge clk);

        // Load back the stored word.
        c = cyc;
        a_d_req = 1; a_d_addr = 32'h2000;
        qa.push_back('{1'b1, c + 3, 32'hDEADBEEF});
        repeat (3) @(negedge clk);
        a_d_req = 0;
        @(negedge clk);

        // Reset during BUSY_D cycle 1: outputs drop without a clock edge, no ready.
        a_d_req = 1; a_d_addr = 32'h300;
        @(negedge clk);
        chk("abort_mem_en_before", 32'(a_mem_en), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("abort_mem_en", 32'(a_mem_en), 32'h0);
        chk("abort_busy", 32'(a_busy), 32'h0);
        chk("abort_d_rdata", a_d_rdata, 32'h0);
        a_d_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        c = cyc;
        a_d_req = 1; a_d_addr = 32'h300;
        qa.push_back('{1'b1, c + 3, 32'hCAFEF00D});
        repeat (3) @(negedge clk);
        a_d_req = 0;
        @(negedge clk);

        // LAT=1: ready two cycles after request; a fetch raised in DONE waits for IDLE.
        c = cyc;
        b_i_req = 1; b_i_addr = 32'h100;
        qb.push_back('{1'b0, c + 2, 32'h00500093});
        @(negedge clk);
        chk("b_busy_c1", 32'(b_busy), 32'h1);
        b_i_req = 0;
        @(negedge clk);
        b_i_req = 1; b_i_addr = 32'h104;
        qb.push_back('{1'b0, c + 5, 32'h00A00113});
        @(negedge clk);
        chk("b_idle_after_done", 32'(b_busy), 32'h0);
        @(negedge clk);
        chk("b_mem_en_c4", 32'(b_mem_en), 32'h1);
        chk("b_mem_addr_c4", b_mem_addr, 32'h104);
        @(negedge clk);
        b_i_req = 0;
        repeat (2) @(negedge clk);

        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
